// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller: frame-synchronous digit shadow, one-hot anodes, blanking gaps.
// All outputs registered; new digits commit only at a frame boundary or while the scan is parked.
module seg7_scan_ctrl #(
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_suppress,
    output logic [3:0]  digit_bcd,
    output logic        digit_dp,
    output logic        digit_blank,
    output logic [3:0]  anode,
    output logic        frame_done,
    output logic        load_pending
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shadow_dig_q, shadow_dig_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [15:0]   active_dig_q, active_dig_d;
    logic [3:0]    active_dp_q, active_dp_d;
    logic          pend_q, pend_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dp_q, dp_d;
    logic          blank_q, blank_d;
    logic          fd_q, fd_d;
    logic          boundary;
    logic          commit;
    logic [3:0]    lz_blank;
    logic          zero_above;

    // A digit is suppressed only if it and every more significant digit are zero with no dp.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = 4'b0000;
        for (int i = 3; i >= 1; i--) begin
            zero_above  = zero_above && (active_dig_d[i*4 +: 4] == 4'd0) && !active_dp_d[i];
            lz_blank[i] = lz_suppress && zero_above;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CW'(1);
        boundary = 1'b0;
        if (!ena) begin
            state_d = ST_BLANK;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d  = ST_BLANK;
                        cnt_d    = '0;
                        idx_d    = idx_q + 2'd1;
                        boundary = (idx_q == 2'd3);
                    end
                end
            endcase
        end

        // Parked scan commits immediately so an idle display never shows stale data.
        commit       = pend_q && (boundary || !ena);
        active_dig_d = commit ? shadow_dig_q : active_dig_q;
        active_dp_d  = commit ? shadow_dp_q  : active_dp_q;
        shadow_dig_d = load ? digits_in : shadow_dig_q;
        shadow_dp_d  = load ? dp_in     : shadow_dp_q;
        pend_d       = load ? 1'b1 : (commit ? 1'b0 : pend_q);

        anode_d = (ena && state_d == ST_DRIVE) ? (4'b0001 << idx_d) : 4'b0000;
        fd_d    = ena && (state_d == ST_DRIVE) && (idx_d == 2'd3) && (cnt_d == DWELL_LAST);
        bcd_d   = active_dig_d[{idx_d, 2'b00} +: 4];
        dp_d    = active_dp_d[idx_d];
        blank_d = !ena || lz_blank[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            shadow_dig_q <= 16'd0;
            shadow_dp_q  <= 4'd0;
            active_dig_q <= 16'd0;
            active_dp_q  <= 4'd0;
            pend_q       <= 1'b0;
            anode_q      <= 4'd0;
            bcd_q        <= 4'd0;
            dp_q         <= 1'b0;
            blank_q      <= 1'b1;
            fd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            active_dig_q <= active_dig_d;
            active_dp_q  <= active_dp_d;
            pend_q       <= pend_d;
            anode_q      <= anode_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            fd_q         <= fd_d;
        end
    end

    assign digit_bcd    = bcd_q;
    assign digit_dp     = dp_q;
    assign digit_blank  = blank_q;
    assign anode        = anode_q;
    assign frame_done   = fd_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DWELL=4, BLANK=2: directed scan sequences, leading-zero table, random run vs frame model.
module tb_seg7_scan_ctrl;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SLOT = DW + BL;
    localparam int FR = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] din = 16'd0;
    logic [3:0]  dpin = 4'd0;
    logic        load = 1'b0;
    logic        lz = 1'b0;
    logic [3:0]  digit_bcd;
    logic        digit_dp;
    logic        digit_blank;
    logic [3:0]  anode;
    logic        frame_done;
    logic        load_pending;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    seg7_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .digits_in(din), .dp_in(dpin),
        .load(load), .lz_suppress(lz), .digit_bcd(digit_bcd), .digit_dp(digit_dp),
        .digit_blank(digit_blank), .anode(anode), .frame_done(frame_done),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame as a plain cycle count.
    int          m_t;
    logic [19:0] m_act, m_sh;
    logic        m_pend;
    logic [3:0]  e_anode, e_bcd;
    logic        e_dp, e_blank, e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_act = 0; m_sh = 0; m_pend = 0;
            e_anode = 0; e_bcd = 0; e_dp = 0; e_blank = 1; e_fd = 0;
        end else begin
            bit bnd, com;
            int ix;
            bnd = ena && (m_t == FR - 1);
            com = m_pend && (bnd || !ena);
            if (com) m_act = m_sh;
            if (load) begin m_sh = {dpin, din}; m_pend = 1; end
            else if (com) m_pend = 0;
            m_t = ena ? (m_t + 1) % FR : 0;
            ix = m_t / SLOT;
            e_anode = (ena && (m_t % SLOT) >= BL) ? 4'(1 << ix) : 4'd0;
            e_fd    = ena && (m_t == FR - 1);
            e_bcd   = 4'(m_act[15:0] >> (4 * ix));
            e_dp    = m_act[16 + ix];
            e_blank = !ena || (lz && ix > 0 && (m_act[15:0] >> (4 * ix)) == 0
                               && (m_act[19:16] >> ix) == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst_n)
            check("model", {anode, digit_bcd, digit_dp, digit_blank, frame_done, load_pending},
                           {e_anode, e_bcd, e_dp, e_blank, e_fd, m_pend});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_anode(input logic [3:0] tgt);
        int n = 0;
        @(negedge clk);
        while (anode !== tgt && n < 60) begin @(negedge clk); n++; end
        check("wait_anode", anode, tgt);
    endtask

    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("wait_frame_done", frame_done, 1);
    endtask

    task automatic capture_frame(output logic [15:0] bcd, output logic [3:0] dp,
                                 output logic [3:0] blk, output logic pend);
        bcd = 0; dp = 0; blk = 0; pend = 0;
        for (int i = 0; i < 4; i++) begin
            wait_anode(4'(1 << i));
            bcd[i*4 +: 4] = digit_bcd;
            dp[i]  = digit_dp;
            blk[i] = digit_blank;
            if (i == 0) pend = load_pending;
        end
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  exp_blank;
        logic [3:0]  exp_dp;
    } lz_vec_t;

    lz_vec_t     tbl [8];
    logic [3:0]  seq1 [24];
    logic [3:0]  bcd2 [4];
    logic [15:0] c_bcd;
    logic [3:0]  c_dp, c_blk;
    logic        c_pend;

    initial begin
        seq1 = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2,
                 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd8, 4'd8, 4'd8, 4'd8};
        bcd2 = '{4'd4, 4'd3, 4'd2, 4'd1};
        tbl[0] = '{16'h0050, 4'b0000, 1'b1, 4'b1100, 4'b0000};
        tbl[1] = '{16'h0050, 4'b0100, 1'b1, 4'b1000, 4'b0100};
        tbl[2] = '{16'h0050, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[3] = '{16'h0000, 4'b0000, 1'b1, 4'b1110, 4'b0000};
        tbl[4] = '{16'h00A0, 4'b0000, 1'b1, 4'b1100, 4'b0000};
        tbl[5] = '{16'h1234, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        tbl[6] = '{16'h0007, 4'b1000, 1'b1, 4'b0000, 4'b1000};
        tbl[7] = '{16'h0300, 4'b0001, 1'b1, 4'b1000, 4'b0001};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {anode, digit_bcd, digit_dp, digit_blank, frame_done, load_pending},
                             {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});

        // Scan sequence from reset with a load in cycle 7
        @(posedge clk); #1;
        rst_n = 1; ena = 1; din = 16'h1234; dpin = 0; chk_on = 1;
        for (int c = 1; c <= 48; c++) begin
            load = (c == 7);
            @(negedge clk);
            check("s1_anode", anode, seq1[(c - 1) % FR]);
            check("s1_frame_done", frame_done, (c % FR) == 0);
            if (c >= 8 && c <= 24) check("s2_pending_set", load_pending, 1);
            if (c <= 24) check("s2_bcd_old", digit_bcd, 0);
            else begin
                check("s2_bcd_new", digit_bcd, bcd2[((c - 1) % FR) / SLOT]);
                check("s2_pending_clr", load_pending, 0);
            end
            tick();
        end

        // Leading-zero table
        foreach (tbl[k]) begin
            din = tbl[k].dig; dpin = tbl[k].dp; lz = tbl[k].lz; load = 1;
            tick();
            load = 0;
            wait_fd();
            capture_frame(c_bcd, c_dp, c_blk, c_pend);
            check("lz_blank", c_blk, tbl[k].exp_blank);
            check("lz_bcd", c_bcd, tbl[k].dig);
            check("lz_dp", c_dp, tbl[k].exp_dp);
            tick();
        end
        lz = 0; dpin = 0;

        // ena dropped in 2nd DRIVE cycle of digit 1, load while parked, resume
        wait_fd();
        tick();
        repeat (9) tick();
        ena = 0;
        @(negedge clk); check("s4_anode_before_drop", anode, 4'b0010);
        tick();
        @(negedge clk); check("s4_parked", {anode, digit_blank, frame_done}, {4'd0, 1'b1, 1'b0});
        tick();
        din = 16'h9876; load = 1;
        tick();
        load = 0;
        @(negedge clk); check("s4_pending", load_pending, 1);
        tick();
        @(negedge clk); check("s4_commit", {load_pending, digit_bcd}, {1'b0, 4'd6});
        tick();
        ena = 1;
        @(negedge clk); check("s4_gap0", anode, 0);
        tick();
        @(negedge clk); check("s4_gap1", anode, 0);
        tick();
        @(negedge clk); check("s4_resume", {anode, digit_bcd, digit_blank}, {4'b0001, 4'd6, 1'b0});

        // Load coinciding with the boundary commit
        wait_fd();
        tick();
        din = 16'h1111; load = 1;
        tick();
        load = 0;
        repeat (22) tick();
        din = 16'h2222; load = 1;
        @(negedge clk); check("s5_boundary", {frame_done, load_pending}, 2'b11);
        tick();
        load = 0;
        capture_frame(c_bcd, c_dp, c_blk, c_pend);
        check("s5_frame1", {c_bcd, c_pend}, {16'h1111, 1'b1});
        capture_frame(c_bcd, c_dp, c_blk, c_pend);
        check("s5_frame2", {c_bcd, c_pend}, {16'h2222, 1'b0});

        // Asynchronous reset mid-DRIVE of digit 2
        tick();
        din = 16'h5555; load = 1;
        tick();
        load = 0;
        wait_anode(4'b0100);
        #2 rst_n = 0;
        #1 check("s6_async", {anode, digit_blank, load_pending}, {4'd0, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check("s6_anode", anode, seq1[c - 1]);
            check("s6_frame_done", frame_done, c == 24);
            tick();
        end

        // Randomized run against the frame model
        lz = 1;
        for (int r = 0; r < 3000; r++) begin
            ena  = ($urandom_range(0, 24) != 0);
            load = ($urandom_range(0, 9) == 0);
            din  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            dpin = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            tick();
        end
        load = 0; ena = 1;
        @(negedge clk);
        chk_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a frame-synchronous copy of four BCD digits plus decimal points. It cycles one-hot anode enables with a dwell period per digit, and inserts a blanking gap between digits to prevent ghosting. It presents the selected nibble to the existing seg7 decoder, so the seconds counter datapath can drive a multi-digit display without tearing.

Parameters:
DWELL_CYCLES, 10000, clock cycles each digit is driven (1 ms at 10 MHz); legal range >= 1.
BLANK_CYCLES, 16, clock cycles all anodes are off between digits; legal range >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  scan enable; low parks the display dark
digits_in  input  16  four BCD nibbles; [3:0] = digit 0 (least significant), [15:12] = digit 3
dp_in  input  4  decimal point per digit; bit i belongs to digit i
load  input  1  single-cycle strobe; captures digits_in/dp_in into the shadow register
lz_suppress  input  1  enables leading-zero blanking
digit_bcd  output  4  nibble for the seg7 decoder
digit_dp  output  1  decimal point for the current digit
digit_blank  output  1  decoder must output all segments off when high
anode  output  4  one-hot anode enable, active high
frame_done  output  1  one-cycle pulse at the end of each full scan frame
load_pending  output  1  shadow holds data not yet committed to the display

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Values during reset: state=BLANK, idx=0, counter=0, shadow=0, active=0, load_pending=0, anode=0, frame_done=0, digit_bcd=0, digit_dp=0, digit_blank=1. All outputs are registered.
- Counter width: clog2(max(DWELL_CYCLES, BLANK_CYCLES)). The counter runs from 0 and clears on every state change.
- State BLANK: anode=0 for exactly BLANK_CYCLES cycles, then go to DRIVE.
  - On entry to DRIVE, anode=1<<idx in the same cycle.
- State DRIVE: anode=1<<idx for exactly DWELL_CYCLES cycles, then go to BLANK with idx=(idx+1) mod 4.
- Frame period: 4*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Frame boundary: the cycle DRIVE of idx 3 ends.
  - frame_done=1 for that one cycle.
  - If load_pending, then active<=shadow and load_pending<=0.
- digit_bcd, digit_dp and digit_blank reflect active[idx] during both the BLANK and the DRIVE of that idx. The decoder therefore settles before its anode turns on.
- load: shadow<=digits_in/dp_in and load_pending<=1 at the next edge. The active digits never change mid-frame.
- load in the same cycle as a frame-boundary commit: active takes the previous shadow contents. The shadow takes the new data and load_pending stays 1; the new data commits at the next boundary.
- Leading-zero suppression: digit i (i = 1..3) is blanked when lz_suppress=1 and, for every j >= i, active nibble j = 0 and dp j = 0.
  - Digit 0 is never suppressed.
  - Nibbles > 9 pass through unmodified and count as non-zero.
- ena=0, synchronous:
  - Next edge: anode=0, state=BLANK, idx=0, counter=0, frame_done=0, digit_blank=1.
  - load is still accepted. A pending shadow commits to active on the first edge with ena=0 and load_pending=1.
  - When ena returns to 1, the scan restarts at BLANK of idx 0 with a full BLANK_CYCLES gap.
- Reset asserted mid-operation: all registers take their reset values immediately, with no clock edge required. anode goes to 0 at once.
- Invariant: anode is never more than one-hot, and is never non-zero in BLANK.

Test Plan:
(all with DWELL_CYCLES=4, BLANK_CYCLES=2)
1. Release reset, ena=1, active=0 -> anode sequence 0000x2, 0001x4, 0000x2, 0010x4, 0000x2, 0100x4, 0000x2, 1000x4. frame_done is high only in the final cycle of 1000 (cycle 24); the pattern then repeats.
2. load with digits_in=16'h1234 in cycle 7 -> load_pending=1 from cycle 8. Displayed nibbles stay 0 until the boundary at cycle 24. The next frame shows digit_bcd 4,3,2,1 under anodes 0001,0010,0100,1000, and load_pending=0.
3. Load 16'h0050 with lz_suppress=1, dp_in=0 -> digit_blank=1 for digits 3 and 2, digit 1 shows 5, digit 0 shows 0. Repeat with dp_in=4'b0100 -> digit 2 is not blanked and shows 0 with digit_dp=1; digit 3 stays blank.
4. Drop ena in the 2nd DRIVE cycle of digit 1 -> anode=0 on the next edge. Load 16'h9876 while idle -> active=9876 and load_pending=0 two edges after the strobe. Raise ena -> anode 0000x2, then 0001 showing 6.
5. Hold shadow=16'h1111 pending and pulse load with 16'h2222 in the boundary cycle -> the next frame shows 1111 with load_pending=1; the frame after shows 2222 with load_pending=0.
6. Assert rst_n=0 asynchronously mid-DRIVE of digit 2 -> anode=0, digit_blank=1 and load_pending=0 before the next clk edge. After release, scan resumes exactly as in scenario 1.
